// File: rtl/dff_puf_pkg.sv
// Shared register map, bit positions and FSM encoding for the DFF PUF controller.
// Pure definitions; no timing or flow control of its own.
package dff_puf_pkg;

  localparam logic [7:0] ADDR_CTRL   = 8'h00;
  localparam logic [7:0] ADDR_STATUS = 8'h01;
  localparam logic [7:0] ADDR_SETTLE = 8'h02;
  localparam logic [7:0] ADDR_GAP    = 8'h03;
  localparam logic [7:0] ADDR_RESP   = 8'h10;
  localparam logic [7:0] ADDR_MASK   = 8'h20;

  localparam int CTRL_START   = 0;
  localparam int CTRL_CLEAR   = 1;
  localparam int CTRL_IRQ_EN  = 2;
  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_CNT_LSB = 16;

  localparam int UCNT_W = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMP0,
    ST_SAMP1,
    ST_SAMP2,
    ST_VOTE
  } state_e;

  // Byte-lane merge of a 16-bit register; only lanes 0 and 1 exist.
  function automatic logic [15:0] merge16(input logic [15:0] cur,
                                          input logic [31:0] din,
                                          input logic [3:0]  we);
    merge16 = cur;
    if (we[0]) merge16[7:0]  = din[7:0];
    if (we[1]) merge16[15:8] = din[15:8];
  endfunction

endpackage

// File: rtl/dff_puf_ctrl_if.sv
// Word-addressed memory bus from the Wishbone bridge: EN/WE/Di/A in, Do out.
// Reads return one cycle after EN; there is no backpressure on this bus.
interface dff_puf_ctrl_if;
  logic        EN;
  logic [3:0]  WE;
  logic [31:0] Di;
  logic [7:0]  A;
  logic [31:0] Do;

  modport master (output EN, output WE, output Di, output A, input Do);
  modport slave  (input EN, input WE, input Di, input A, output Do);
endinterface

// File: rtl/puf_majority3.sv
// Bitwise 2-of-3 vote over three PUF samples, instability mask and its popcount.
// Purely combinational; no handshake.
module puf_majority3
  import dff_puf_pkg::*;
#(
  parameter int PUF_BITS = 128
) (
  input  logic [PUF_BITS-1:0] s0_i,
  input  logic [PUF_BITS-1:0] s1_i,
  input  logic [PUF_BITS-1:0] s2_i,
  output logic [PUF_BITS-1:0] resp_o,
  output logic [PUF_BITS-1:0] mask_o,
  output logic [UCNT_W-1:0]   popcount_o
);

  assign resp_o = (s0_i & s1_i) | (s1_i & s2_i) | (s0_i & s2_i);
  assign mask_o = (s0_i ^ s1_i) | (s1_i ^ s2_i);

  always_comb begin
    popcount_o = '0;
    for (int i = 0; i < PUF_BITS; i++) begin
      popcount_o = popcount_o + UCNT_W'(mask_o[i]);
    end
  end

endmodule

// File: rtl/dff_puf_ctrl.sv
// DFF PUF controller: CSR file plus settle/sample x3/vote sequencer behind the bridge bus.
// Reads have 1-cycle latency; the bus is never stalled, START while busy is dropped.
module dff_puf_ctrl
  import dff_puf_pkg::*;
#(
  parameter int PUF_BITS   = 128,
  parameter int SETTLE_RST = 16,
  parameter int GAP_RST    = 4
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  dff_puf_ctrl_if.slave       bus,
  output logic                puf_en,
  input  logic [PUF_BITS-1:0] puf_raw,
  output logic                irq
);

  localparam int WORDS = PUF_BITS / 32;

  state_e                state_q, state_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [15:0]           settle_q, settle_d;
  logic [15:0]           gap_q, gap_d;
  logic                  puf_en_q, puf_en_d;
  logic                  irq_en_q, irq_en_d;
  logic                  done_q, done_d;
  logic [PUF_BITS-1:0]   s0_q, s0_d, s1_q, s1_d, s2_q, s2_d;
  logic [PUF_BITS-1:0]   resp_q, resp_d, mask_q, mask_d;
  logic [UCNT_W-1:0]     ucnt_q, ucnt_d;
  logic [31:0]           rdata_q, rdata_d;

  logic [PUF_BITS-1:0]   vote_resp, vote_mask;
  logic [UCNT_W-1:0]     vote_cnt;
  logic                  wr, rd, ctrl_wr, busy, start, clear;

  puf_majority3 #(.PUF_BITS(PUF_BITS)) u_vote (
    .s0_i       (s0_q),
    .s1_i       (s1_q),
    .s2_i       (s2_q),
    .resp_o     (vote_resp),
    .mask_o     (vote_mask),
    .popcount_o (vote_cnt)
  );

  assign wr      = bus.EN && (bus.WE != 4'b0000);
  assign rd      = bus.EN && (bus.WE == 4'b0000);
  assign ctrl_wr = wr && (bus.A == ADDR_CTRL) && bus.WE[0];
  assign busy    = (state_q != ST_IDLE);
  assign start   = ctrl_wr && bus.Di[CTRL_START];
  assign clear   = ctrl_wr && bus.Di[CTRL_CLEAR];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    settle_d = settle_q;
    gap_d    = gap_q;
    puf_en_d = puf_en_q;
    irq_en_d = irq_en_q;
    done_d   = done_q;
    s0_d     = s0_q;
    s1_d     = s1_q;
    s2_d     = s2_q;
    resp_d   = resp_q;
    mask_d   = mask_q;
    ucnt_d   = ucnt_q;

    if (wr && bus.A == ADDR_SETTLE) settle_d = merge16(settle_q, bus.Di, bus.WE);
    if (wr && bus.A == ADDR_GAP)    gap_d    = merge16(gap_q, bus.Di, bus.WE);
    if (ctrl_wr) irq_en_d = bus.Di[CTRL_IRQ_EN];
    if (wr && bus.A == ADDR_STATUS && bus.WE[0] && bus.Di[STAT_DONE]) done_d = 1'b0;

    if (clear && !busy) begin
      resp_d = '0;
      mask_d = '0;
      ucnt_d = '0;
      done_d = 1'b0;
    end

    // Each wait state captures on the edge its counter is already zero.
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_SETTLE;
          cnt_d    = settle_q;
          puf_en_d = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == 16'd0) begin
          s0_d    = puf_raw;
          cnt_d   = gap_q;
          state_d = ST_SAMP1;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_SAMP1: begin
        if (cnt_q == 16'd0) begin
          s1_d    = puf_raw;
          cnt_d   = gap_q;
          state_d = ST_SAMP2;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_SAMP2: begin
        if (cnt_q == 16'd0) begin
          s2_d     = puf_raw;
          puf_en_d = 1'b0;
          state_d  = ST_VOTE;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_VOTE: begin
        resp_d  = vote_resp;
        mask_d  = vote_mask;
        ucnt_d  = vote_cnt;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        puf_en_d = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    rdata_d = rdata_q;
    if (rd) begin
      rdata_d = '0;
      case (bus.A)
        ADDR_CTRL:   rdata_d[CTRL_IRQ_EN] = irq_en_q;
        ADDR_STATUS: begin
          rdata_d[STAT_BUSY]                  = busy;
          rdata_d[STAT_DONE]                  = done_q;
          rdata_d[STAT_CNT_LSB +: UCNT_W]     = ucnt_q;
        end
        ADDR_SETTLE: rdata_d[15:0] = settle_q;
        ADDR_GAP:    rdata_d[15:0] = gap_q;
        default:     rdata_d = '0;
      endcase
      for (int w = 0; w < WORDS; w++) begin
        if (bus.A == ADDR_RESP + 8'(w)) rdata_d = resp_q[32*w +: 32];
        if (bus.A == ADDR_MASK + 8'(w)) rdata_d = mask_q[32*w +: 32];
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      settle_q <= 16'(SETTLE_RST);
      gap_q    <= 16'(GAP_RST);
      puf_en_q <= 1'b0;
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
      s0_q     <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
      resp_q   <= '0;
      mask_q   <= '0;
      ucnt_q   <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      settle_q <= settle_d;
      gap_q    <= gap_d;
      puf_en_q <= puf_en_d;
      irq_en_q <= irq_en_d;
      done_q   <= done_d;
      s0_q     <= s0_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      resp_q   <= resp_d;
      mask_q   <= mask_d;
      ucnt_q   <= ucnt_d;
      rdata_q  <= rdata_d;
    end
  end

  assign bus.Do = rdata_q;
  assign puf_en = puf_en_q;
  assign irq    = done_q & irq_en_q;

endmodule

// File: tb/tb_dff_puf_ctrl.sv
// Self-checking bench for dff_puf_ctrl: randomized PUF sample streams against a per-bit vote model.
module tb_dff_puf_ctrl;

  logic         clk;
  logic         wb_rst_i;
  logic         puf_en;
  logic         irq;
  logic [127:0] puf_raw;

  dff_puf_ctrl_if bus ();

  dff_puf_ctrl #(.PUF_BITS(128), .SETTLE_RST(16), .GAP_RST(4)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (wb_rst_i),
    .bus      (bus),
    .puf_en   (puf_en),
    .puf_raw  (puf_raw),
    .irq      (irq)
  );

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;

  // raw_tab[e % 256] is the array value presented at posedge number e
  logic [127:0] raw_tab [256];

  logic [127:0] m_resp, m_mask;
  logic [9:0]   m_cnt;
  logic         m_done, m_irq_en;
  logic [15:0]  m_settle, m_gap;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) puf_raw = raw_tab[(cyc + 1) % 256];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic model_reset();
    m_resp = '0; m_mask = '0; m_cnt = '0;
    m_done = 1'b0; m_irq_en = 1'b0;
    m_settle = 16'd16; m_gap = 16'd4;
  endtask

  task automatic model_vote(input logic [127:0] a, b, c);
    int n, tot;
    tot = 0;
    for (int i = 0; i < 128; i++) begin
      n = int'(a[i]) + int'(b[i]) + int'(c[i]);
      m_resp[i] = (n >= 2);
      m_mask[i] = (n == 1) || (n == 2);
      if (m_mask[i]) tot++;
    end
    m_cnt = tot[9:0];
  endtask

  task automatic bus_wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] we);
    @(negedge clk);
    bus.EN = 1'b1; bus.WE = we; bus.A = a; bus.Di = d;
    @(negedge clk);
    bus.EN = 1'b0; bus.WE = 4'b0000;
  endtask

  task automatic bus_rd(input logic [7:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.EN = 1'b1; bus.WE = 4'b0000; bus.A = a;
    @(negedge clk);
    bus.EN = 1'b0;
    d = bus.Do;
  endtask

  task automatic check_regs(input string nm);
    logic [31:0] d, exp;
    for (int w = 0; w < 4; w++) begin
      bus_rd(8'h10 + 8'(w), d);
      n_checks++;
      if (d !== m_resp[32*w +: 32]) begin
        n_fails++;
        $display("FAIL %s resp[%0d]: got %h expected %h", nm, w, d, m_resp[32*w +: 32]);
      end
      bus_rd(8'h20 + 8'(w), d);
      n_checks++;
      if (d !== m_mask[32*w +: 32]) begin
        n_fails++;
        $display("FAIL %s mask[%0d]: got %h expected %h", nm, w, d, m_mask[32*w +: 32]);
      end
    end
    exp = {6'd0, m_cnt, 14'd0, m_done, 1'b0};
    bus_rd(8'h01, d);
    n_checks++;
    if (d !== exp) begin
      n_fails++;
      $display("FAIL %s status: got %h expected %h", nm, d, exp);
    end
    exp = {29'd0, m_irq_en, 2'b00};
    bus_rd(8'h00, d);
    n_checks++;
    if (d !== exp) begin
      n_fails++;
      $display("FAIL %s ctrl: got %h expected %h", nm, d, exp);
    end
    bus_rd(8'h02, d);
    n_checks++;
    if (d !== {16'd0, m_settle}) begin
      n_fails++;
      $display("FAIL %s settle: got %h expected %h", nm, d, m_settle);
    end
    bus_rd(8'h03, d);
    n_checks++;
    if (d !== {16'd0, m_gap}) begin
      n_fails++;
      $display("FAIL %s gap: got %h expected %h", nm, d, m_gap);
    end
  endtask

  // col_kind 1: START|CLEAR write at offset col_at; 2: DONE W1C landing on the vote edge
  task automatic run_seq(input string nm, input logic [127:0] a, b, c,
                         input int s, g, input bit ien, input bit with_clr,
                         input int col_kind, input int col_at);
    int  tt, v;
    bit  pre, exp_pen, exp_irq;
    bus_wr(8'h02, 32'(s), 4'b0011); m_settle = 16'(s);
    bus_wr(8'h03, 32'(g), 4'b0011); m_gap    = 16'(g);
    pre = m_done && !with_clr;
    v   = 4 + s + 2 * g;
    @(negedge clk);
    tt = cyc + 1;
    for (int e = tt + 1; e <= tt + v + 2; e++) raw_tab[e % 256] = rnd128();
    raw_tab[(tt + 1 + s) % 256]         = a;
    raw_tab[(tt + 2 + s + g) % 256]     = b;
    raw_tab[(tt + 3 + s + 2 * g) % 256] = c;
    bus.EN = 1'b1; bus.WE = 4'b0001; bus.A = 8'h00; bus.Di = {29'd0, ien, with_clr, 1'b1};
    for (int k = 0; k <= v + 1; k++) begin
      @(negedge clk);
      bus.EN = 1'b0; bus.WE = 4'b0000;
      exp_pen = (k < v - 1);
      exp_irq = ien && ((k >= v) || pre);
      n_checks++;
      if (puf_en !== exp_pen) begin
        n_fails++;
        $display("FAIL %s puf_en at +%0d: got %b expected %b", nm, k, puf_en, exp_pen);
      end
      n_checks++;
      if (irq !== exp_irq) begin
        n_fails++;
        $display("FAIL %s irq at +%0d: got %b expected %b", nm, k, irq, exp_irq);
      end
      if (col_kind == 1 && k == col_at) begin
        bus.EN = 1'b1; bus.WE = 4'b0001; bus.A = 8'h00; bus.Di = {29'd0, ien, 2'b11};
      end
      if (col_kind == 2 && k == v - 1) begin
        bus.EN = 1'b1; bus.WE = 4'b0001; bus.A = 8'h01; bus.Di = 32'h2;
      end
    end
    model_vote(a, b, c);
    m_done = 1'b1;
    m_irq_en = ien;
    check_regs(nm);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    n_checks++;
    if (bus.Do !== 32'h0 || puf_en !== 1'b0 || irq !== 1'b0) begin
      n_fails++;
      $display("FAIL reset_outputs: got Do=%h puf_en=%b irq=%b expected 0/0/0", bus.Do, puf_en, irq);
    end
    @(negedge clk);
    bus.EN = 1'b1; bus.WE = 4'b0000; bus.A = 8'h02;
    #1;
    n_checks++;
    if (bus.Do !== 32'h0) begin
      n_fails++;
      $display("FAIL read_latency_early: got %h expected 00000000", bus.Do);
    end
    @(negedge clk);
    bus.EN = 1'b0;
    n_checks++;
    if (bus.Do !== 32'd16) begin
      n_fails++;
      $display("FAIL read_latency_settle: got %h expected 00000010", bus.Do);
    end
    bus.A = 8'h03;
    @(negedge clk);
    n_checks++;
    if (bus.Do !== 32'd16) begin
      n_fails++;
      $display("FAIL read_hold: got %h expected 00000010", bus.Do);
    end
    bus_rd(8'h05, d);
    n_checks++;
    if (d !== 32'h0) begin
      n_fails++;
      $display("FAIL unmapped_read: got %h expected 00000000", d);
    end
    bus_rd(8'h14, d);
    n_checks++;
    if (d !== 32'h0) begin
      n_fails++;
      $display("FAIL resp_past_end: got %h expected 00000000", d);
    end
    check_regs("reset");
  endtask

  task automatic test_byte_lanes();
    logic [31:0] d;
    logic [3:0]  we;
    bus_wr(8'h02, 32'h0000_ABCD, 4'b0001);
    m_settle = {m_settle[15:8], 8'hCD};
    bus_rd(8'h02, d);
    n_checks++;
    if (d !== 32'h0000_00CD) begin
      n_fails++;
      $display("FAIL settle_byte0: got %h expected 000000cd", d);
    end
    for (int i = 0; i < 4; i++) begin
      d  = $urandom;
      we = 4'($urandom_range(1, 15));
      bus_wr(8'h03, d, we);
      for (int b = 0; b < 2; b++) if (we[b]) m_gap[8*b +: 8] = d[8*b +: 8];
    end
    bus_wr(8'h10, 32'hFFFF_FFFF, 4'b1111);
    bus_wr(8'h21, 32'hFFFF_FFFF, 4'b1111);
    bus_wr(8'h00, 32'h0000_0404, 4'b0010);
    check_regs("byte_lanes");
  endtask

  task automatic test_clear();
    bus_wr(8'h00, {29'd0, m_irq_en, 2'b10}, 4'b0001);
    m_resp = '0; m_mask = '0; m_cnt = '0; m_done = 1'b0;
    n_checks++;
    if (irq !== 1'b0) begin
      n_fails++;
      $display("FAIL clear_irq: got %b expected 0", irq);
    end
    check_regs("clear");
  endtask

  task automatic test_collisions();
    logic [127:0] base;
    base = rnd128();
    run_seq("pre_collide", base, base ^ 128'h1, base, 1, 1, 1'b1, 1'b0, 0, 0);
    run_seq("start_clear_busy", rnd128(), rnd128(), rnd128(), 3, 2, 1'b1, 1'b0, 1, 2);
    run_seq("w1c_vs_vote", rnd128(), rnd128(), rnd128(), 0, 1, 1'b1, 1'b0, 2, 0);
    run_seq("clear_and_start", base, base, base ^ {128{1'b1}}, 2, 0, 1'b1, 1'b1, 0, 0);
  endtask

  task automatic test_random();
    logic [127:0] base;
    for (int r = 0; r < 6; r++) begin
      base = rnd128();
      run_seq("random", base ^ (rnd128() & rnd128() & rnd128()),
              base ^ (rnd128() & rnd128() & rnd128()),
              base ^ (rnd128() & rnd128() & rnd128()),
              int'($urandom_range(0, 6)), int'($urandom_range(0, 6)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 0);
    end
  endtask

  task automatic test_irq_reset();
    run_seq("irq_run", rnd128(), rnd128(), rnd128(), 1, 0, 1'b1, 1'b0, 0, 0);
    bus_wr(8'h01, 32'h2, 4'b0001);
    m_done = 1'b0;
    n_checks++;
    if (irq !== 1'b0) begin
      n_fails++;
      $display("FAIL irq_w1c: got %b expected 0", irq);
    end
    bus_wr(8'h02, 32'd2, 4'b0011);
    bus_wr(8'h03, 32'd5, 4'b0011);
    @(negedge clk);
    bus.EN = 1'b1; bus.WE = 4'b0001; bus.A = 8'h00; bus.Di = 32'h5;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      bus.EN = 1'b0; bus.WE = 4'b0000;
    end
    n_checks++;
    if (puf_en !== 1'b1) begin
      n_fails++;
      $display("FAIL samp1_puf_en: got %b expected 1", puf_en);
    end
    wb_rst_i = 1'b1;
    @(negedge clk);
    n_checks++;
    if (puf_en !== 1'b0 || irq !== 1'b0) begin
      n_fails++;
      $display("FAIL reset_abort: got puf_en=%b irq=%b expected 0/0", puf_en, irq);
    end
    wb_rst_i = 1'b0;
    model_reset();
    check_regs("after_abort");
  endtask

  initial begin
    logic [127:0] pat;
    for (int i = 0; i < 256; i++) raw_tab[i] = '0;
    bus.EN = 1'b0; bus.WE = 4'b0000; bus.A = 8'h00; bus.Di = 32'h0;
    wb_rst_i = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    wb_rst_i = 1'b0;

    test_reset();
    test_byte_lanes();
    pat = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
    run_seq("stable", pat, pat, pat, 2, 0, 1'b0, 1'b0, 0, 0);
    run_seq("flip", 128'h0, 128'h0, {96'h0, 32'hFFFF_0000}, 1, 2, 1'b1, 1'b0, 0, 0);
    test_clear();
    test_collisions();
    test_random();
    test_irq_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
